// File: rtl/pc_pkg.sv
// Shared types for the program-counter unit: operation codes and control FSM states.
package pc_pkg;

  typedef enum logic [2:0] {
    OP_HOLD   = 3'b000,
    OP_INC    = 3'b001,
    OP_BRANCH = 3'b010,
    OP_JUMP   = 3'b011,
    OP_CALL   = 3'b100,
    OP_RET    = 3'b101
  } op_t;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HALT  = 2'd1,
    ST_ERROR = 2'd2
  } state_t;

endpackage

// File: rtl/pc_ret_stack.sv
// Return-address LIFO for pc_unit. Push on full and pop on empty are ignored;
// the caller is expected to flag those as errors.
module pc_ret_stack #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned DW   = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top_data,
  output logic [DW-1:0]    depth,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DW-1:0]    depth_q, depth_d;
  logic [DW-1:0]    top_idx;
  logic [AW-1:0]    wr_ptr, rd_ptr;

  assign full    = (depth_q == DW'(DEPTH));
  assign empty   = (depth_q == '0);
  assign depth   = depth_q;
  assign top_idx = depth_q - DW'(1);
  assign wr_ptr  = AW'(depth_q);
  assign rd_ptr  = AW'(top_idx);
  assign top_data = mem[rd_ptr];

  always_comb begin
    depth_d = depth_q;
    if (push && !full) begin
      depth_d = depth_q + DW'(1);
    end else if (pop && !empty) begin
      depth_d = depth_q - DW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      depth_q <= '0;
    end else begin
      depth_q <= depth_d;
    end
  end

  // Entry contents need no reset: only slots below depth_q are ever read.
  always_ff @(posedge clock) begin
    if (reset && push && !full) begin
      mem[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: increment, branch, jump, call/return, halt and sticky error.
// Define PC_WRAP_TRAP_EN to turn address wrap-around into an error instead of modulo wrap.
module pc_unit
  import pc_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned STEP      = 1,
  parameter int unsigned RESET_VEC = 0,
  parameter int unsigned OFFS_W    = 8,
  parameter int unsigned DEPTH     = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         esc_pc,
  input  logic [2:0]                   op,
  input  logic [WIDTH-1:0]             target,
  input  logic [OFFS_W-1:0]            offset,
  input  logic                         halt_req,
  input  logic                         resume,
  output logic [WIDTH-1:0]             pc_out,
  output logic [$clog2(DEPTH+1)-1:0]   stack_depth,
  output logic                         stack_full,
  output logic                         stack_empty,
  output logic                         halted,
  output logic                         error
);

`ifdef PC_WRAP_TRAP_EN
  localparam bit WrapTrap = 1'b1;
`else
  localparam bit WrapTrap = 1'b0;
`endif

  // Wide enough to hold pc plus a sign-extended offset without losing the wrap indication.
  localparam int unsigned EW = ((WIDTH > OFFS_W) ? WIDTH : OFFS_W) + 2;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   pc_q, pc_d;
  logic [WIDTH:0]     seq_sum;
  logic signed [EW-1:0] br_sum;
  logic               seq_wrap, br_wrap;
  logic               push, pop;
  logic [WIDTH-1:0]   stack_top;

  assign seq_sum  = {1'b0, pc_q} + (WIDTH + 1)'(STEP);
  assign seq_wrap = seq_sum[WIDTH];
  assign br_sum   = $signed({{(EW - WIDTH){1'b0}}, pc_q}) + EW'($signed(offset));
  assign br_wrap  = (br_sum[EW-1:WIDTH] != '0);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    push    = 1'b0;
    pop     = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (halt_req) begin
          state_d = ST_HALT;
        end else if (esc_pc) begin
          case (op)
            OP_INC: begin
              if (WrapTrap && seq_wrap) state_d = ST_ERROR;
              else                      pc_d    = seq_sum[WIDTH-1:0];
            end
            OP_BRANCH: begin
              if (WrapTrap && br_wrap) state_d = ST_ERROR;
              else                     pc_d    = br_sum[WIDTH-1:0];
            end
            OP_JUMP: pc_d = target;
            OP_CALL: begin
              if (stack_full || (WrapTrap && seq_wrap)) begin
                state_d = ST_ERROR;
              end else begin
                push = 1'b1;
                pc_d = target;
              end
            end
            OP_RET: begin
              if (stack_empty) begin
                state_d = ST_ERROR;
              end else begin
                pop  = 1'b1;
                pc_d = stack_top;
              end
            end
            default: ;
          endcase
        end
      end
      ST_HALT: begin
        if (resume && !halt_req) state_d = ST_RUN;
      end
      ST_ERROR: ;
      default: state_d = ST_ERROR;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= ST_RUN;
      pc_q    <= WIDTH'(RESET_VEC);
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  pc_ret_stack #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_stack (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .push_data (seq_sum[WIDTH-1:0]),
    .top_data  (stack_top),
    .depth     (stack_depth),
    .full      (stack_full),
    .empty     (stack_empty)
  );

  assign pc_out = pc_q;
  assign halted = (state_q == ST_HALT);
  assign error  = (state_q == ST_ERROR);

endmodule
